// File: rtl/top_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the UART echo system.
package top_pkg;
  localparam int CLK_HZ     = 16000000;
  localparam int BAUD       = 19200;
  localparam int OVERSAMPLE = 16;
  // Rounded clocks per oversample tick (52 at 16 MHz / 19200 baud).
  localparam int TICK_DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {CPU_IDLE, CPU_WAIT_RX, CPU_SEND_LF, CPU_HALT} cpu_state_e;
  typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } byte_req_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/top_cpu.sv
`timescale 1ns/1ps
// Echo controller: forwards ECHO_COUNT bytes RX->TX, appends LF, then halts for good.
module cpu import top_pkg::*; #(
  parameter int ECHO_COUNT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_empty,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_pop,
  input  logic       i_tx_full,
  output byte_req_t  o_tx_req
);
  localparam int CW = $clog2(ECHO_COUNT + 1);

  cpu_state_e    r_state;
  logic [CW-1:0] r_echo_cnt;
  logic          halt;
  logic          w_xfer;

  assign w_xfer   = (r_state == CPU_WAIT_RX) && !halt && !i_rx_empty && !i_tx_full;
  assign o_rx_pop = w_xfer;

  always_comb begin
    o_tx_req = '0;
    if (w_xfer) begin
      o_tx_req.vld  = 1'b1;
      o_tx_req.data = i_rx_data;
    end else if (r_state == CPU_SEND_LF && !i_tx_full) begin
      o_tx_req.vld  = 1'b1;
      o_tx_req.data = LF;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= CPU_IDLE;
      r_echo_cnt <= '0;
      halt       <= 1'b0;
    end else begin
      case (r_state)
        CPU_IDLE:    r_state <= CPU_WAIT_RX;
        CPU_WAIT_RX: if (w_xfer) begin
          r_echo_cnt <= r_echo_cnt + 1'b1;
          if (r_echo_cnt == CW'(ECHO_COUNT - 1)) r_state <= CPU_SEND_LF;
        end
        CPU_SEND_LF: if (!i_tx_full) begin
          r_state <= CPU_HALT;
          halt    <= 1'b1;
        end
        CPU_HALT:    halt    <= 1'b1;
        default:     r_state <= CPU_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/top_sync_fifo.sv
`timescale 1ns/1ps
// First-word fall-through FIFO; pointers wrap modulo DEPTH (power of 2).
module sync_fifo import top_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/top_uart.sv
`timescale 1ns/1ps
// 8N1 UART: free-running oversample tick, RX with start re-check, TX, RX/TX FIFOs.
module uart import top_pkg::*; #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_tx,
  input  logic       i_rx_pop,
  output logic [7:0] o_rx_data,
  output logic       o_rx_empty,
  input  byte_req_t  i_tx_req,
  output logic       o_tx_full
);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] r_baud_cnt;
  logic          r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_baud_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_baud_cnt == DIV_LAST) begin
      r_baud_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
      r_tick     <= 1'b0;
    end
  end

  // [0],[1] synchronise rx; [2] holds the previous synchronised level for edge detect.
  logic [2:0]  r_rx_sync;
  ser_state_e  r_rx_st;
  logic [3:0]  r_rx_tick;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_push;
  logic        w_rx_s, w_rx_fall, w_rx_full;

  assign w_rx_s    = r_rx_sync[1];
  assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_sync  <= 3'b111;
      r_rx_st    <= SER_IDLE;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_push  <= 1'b0;
    end else begin
      r_rx_sync <= {r_rx_sync[1:0], i_rx};
      r_rx_push <= 1'b0;
      case (r_rx_st)
        SER_IDLE: if (w_rx_fall) begin
          r_rx_st   <= SER_START;
          r_rx_tick <= '0;
        end
        SER_START: if (r_tick) begin
          if (r_rx_tick == 4'd7) begin
            r_rx_tick <= '0;
            r_rx_bit  <= '0;
            r_rx_st   <= w_rx_s ? SER_IDLE : SER_DATA;
          end else begin
            r_rx_tick <= r_rx_tick + 1'b1;
          end
        end
        SER_DATA: if (r_tick) begin
          r_rx_tick <= r_rx_tick + 1'b1;
          if (r_rx_tick == 4'd15) begin
            r_rx_shift <= {w_rx_s, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) r_rx_st <= SER_STOP;
          end
        end
        SER_STOP: if (r_tick) begin
          r_rx_tick <= r_rx_tick + 1'b1;
          if (r_rx_tick == 4'd15) begin
            r_rx_push <= w_rx_s;
            r_rx_st   <= SER_IDLE;
          end
        end
        default: r_rx_st <= SER_IDLE;
      endcase
    end
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_rx_push & ~w_rx_full),
    .i_data  (r_rx_shift),
    .i_pop   (i_rx_pop),
    .o_data  (o_rx_data),
    .o_empty (o_rx_empty),
    .o_full  (w_rx_full)
  );

  // TX keeps its own divider phase-aligned to the frame so every bit is exactly 16 ticks.
  ser_state_e    r_tx_st;
  logic [DW-1:0] r_tx_div;
  logic [3:0]    r_tx_tick;
  logic [2:0]    r_tx_bit;
  logic          r_tx;
  logic [7:0]    tx_fifo_out;
  logic          w_tx_fifo_empty, w_tx_bit_end;
  logic          tx_done_tick, tx_empty;

  assign w_tx_bit_end = (r_tx_div == DIV_LAST) && (r_tx_tick == 4'd15);
  assign tx_done_tick = (r_tx_st == SER_STOP) && w_tx_bit_end;
  assign tx_empty     = w_tx_fifo_empty && (r_tx_st == SER_IDLE);
  assign o_tx         = r_tx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_st   <= SER_IDLE;
      r_tx_div  <= '0;
      r_tx_tick <= '0;
      r_tx_bit  <= '0;
      r_tx      <= 1'b1;
    end else begin
      if (r_tx_st != SER_IDLE) begin
        if (r_tx_div == DIV_LAST) begin
          r_tx_div  <= '0;
          r_tx_tick <= r_tx_tick + 1'b1;
        end else begin
          r_tx_div <= r_tx_div + 1'b1;
        end
      end
      case (r_tx_st)
        SER_IDLE: if (!tx_empty) begin
          r_tx_st   <= SER_START;
          r_tx      <= 1'b0;
          r_tx_div  <= '0;
          r_tx_tick <= '0;
        end
        SER_START: if (w_tx_bit_end) begin
          r_tx_st  <= SER_DATA;
          r_tx_bit <= '0;
          r_tx     <= tx_fifo_out[0];
        end
        SER_DATA: if (w_tx_bit_end) begin
          r_tx_bit <= r_tx_bit + 1'b1;
          if (r_tx_bit == 3'd7) begin
            r_tx_st <= SER_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_tx <= tx_fifo_out[r_tx_bit + 3'd1];
          end
        end
        SER_STOP: if (w_tx_bit_end) r_tx_st <= SER_IDLE;
        default:  r_tx_st <= SER_IDLE;
      endcase
    end
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_tx_req.vld),
    .i_data  (i_tx_req.data),
    .i_pop   (tx_done_tick),
    .o_data  (tx_fifo_out),
    .o_empty (w_tx_fifo_empty),
    .o_full  (o_tx_full)
  );
endmodule

// File: rtl/top.sv
`timescale 1ns/1ps
// System top: echo controller driving a UART with RX/TX FIFOs.
module top import top_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int ECHO_COUNT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic tx
);
  logic       w_rx_pop, w_rx_empty, w_tx_full;
  logic [7:0] w_rx_data;
  byte_req_t  w_tx_req;

  uart #(.FIFO_DEPTH(FIFO_DEPTH)) uart (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_rx       (rx),
    .o_tx       (tx),
    .i_rx_pop   (w_rx_pop),
    .o_rx_data  (w_rx_data),
    .o_rx_empty (w_rx_empty),
    .i_tx_req   (w_tx_req),
    .o_tx_full  (w_tx_full)
  );

  cpu #(.ECHO_COUNT(ECHO_COUNT)) cpu (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_rx_empty (w_rx_empty),
    .i_rx_data  (w_rx_data),
    .o_rx_pop   (w_rx_pop),
    .i_tx_full  (w_tx_full),
    .o_tx_req   (w_tx_req)
  );
endmodule

// File: tb/tb_top.sv
`timescale 1ns/1ps
// Bench for the UART echo system: directed frame table, halt/reset sequences, random echo run.
module tb_top;
  import top_pkg::*;

  localparam real BIT_NS = 1.0e9 / 19200.0;
  localparam int  ECHO   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic rx = 1'b1;
  logic tx;

  top dut (.clk(clk), .reset_n(reset_n), .rx(rx), .tx(tx));

  always #31.25 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Observers
  int        rx_push_cnt = 0;
  int        tx_fall_cnt = 0;
  logic [7:0] done_q[$];
  logic [7:0] mon_q[$];
  realtime   done_t[$];
  realtime   fall_t[$];
  bit        mon_en = 1'b1;

  always @(negedge clk) begin
    if (reset_n && dut.uart.r_rx_push && !dut.uart.w_rx_full) rx_push_cnt++;
    if (reset_n && dut.uart.tx_done_tick) begin
      done_q.push_back(dut.uart.tx_fifo_out);
      done_t.push_back($realtime);
    end
  end

  always @(negedge tx) if (reset_n) tx_fall_cnt++;

  // Line decoder: samples the tx wire at bench bit centres.
  initial begin : tx_decode
    logic [7:0] d;
    bit         ok;
    realtime    t0;
    forever begin
      @(negedge tx);
      t0 = $realtime;
      ok = mon_en;
      #(BIT_NS / 2.0);
      if (ok) check("tx_start_bit", {31'd0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        d[i] = tx;
      end
      #(BIT_NS);
      ok = ok & mon_en;
      if (ok) begin
        check("tx_stop_bit", {31'd0, tx}, 32'd1);
        mon_q.push_back(d);
        fall_t.push_back(t0);
      end
    end
  end

  // Reference model: first ECHO accepted bytes are echoed, then one LF; later bytes are ignored.
  logic [7:0] exp_q[$];
  int         m_echoed = 0;

  function automatic void model_frame(input logic [7:0] d, input logic stop_ok);
    if (stop_ok && m_echoed < ECHO) begin
      exp_q.push_back(d);
      m_echoed++;
      if (m_echoed == ECHO) exp_q.push_back(LF);
    end
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic stop, input real gap_ns);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(BIT_NS);
    end
    rx = stop;
    #(BIT_NS);
    rx = 1'b1;
    #(gap_ns);
  endtask

  task automatic wait_halt_empty(input string name, input int max_cyc);
    int n = 0;
    while (!(dut.cpu.halt && dut.uart.tx_empty) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, dut.cpu.halt && dut.uart.tx_empty}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int target, input int max_cyc);
    int n = 0;
    while (done_q.size() < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, done_q.size(), target);
  endtask

  task automatic compare_echo(input string tag, input int n);
    real dt;
    for (int i = 0; i < n; i++) begin
      if (i < done_q.size())
        check($sformatf("%s_done_byte%0d", tag, i), {24'd0, done_q[i]}, {24'd0, exp_q[i]});
      if (i < mon_q.size())
        check($sformatf("%s_line_byte%0d", tag, i), {24'd0, mon_q[i]}, {24'd0, exp_q[i]});
      if (i < done_t.size() && i < fall_t.size()) begin
        dt = done_t[i] - fall_t[i];
        check($sformatf("%s_frame_time%0d", tag, i),
              {31'd0, (dt > 0.98 * 10.0 * BIT_NS) && (dt < 1.02 * 10.0 * BIT_NS)}, 32'd1);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_rx;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [7:0] b0, b1;
    int base_rx, base_fall, base_done;

    vecs[0] = '{data: 8'h55, stop: 1'b0, exp_rx: 0};
    vecs[1] = '{data: 8'h31, stop: 1'b1, exp_rx: 1};
    vecs[2] = '{data: 8'h32, stop: 1'b1, exp_rx: 2};

    #5 reset_n = 1'b0;
    #200;
    check("rst_tx",        {31'd0, tx},                     32'd1);
    check("rst_tx_empty",  {31'd0, dut.uart.tx_empty},      32'd1);
    check("rst_halt",      {31'd0, dut.cpu.halt},           32'd0);
    check("rst_done_tick", {31'd0, dut.uart.tx_done_tick},  32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Short low pulse must be rejected by the mid-start-bit re-check.
    rx = 1'b0;
    #10000;
    rx = 1'b1;
    #50000;
    check("glitch_no_rx", rx_push_cnt, 0);

    for (int i = 0; i < 3; i++) begin
      send_byte(vecs[i].data, vecs[i].stop, BIT_NS);
      model_frame(vecs[i].data, vecs[i].stop);
      check($sformatf("rx_accept_%0d", i), rx_push_cnt, vecs[i].exp_rx);
    end

    wait_halt_empty("halt_and_empty", 40000);
    check("p1_done_count", done_q.size(), exp_q.size());
    check("p1_line_count", mon_q.size(),  exp_q.size());
    compare_echo("p1", exp_q.size());

    // Halted: bytes still land in RX but nothing is transmitted.
    base_rx   = rx_push_cnt;
    base_fall = tx_fall_cnt;
    base_done = done_q.size();
    send_byte(8'h33, 1'b1, 2.0 * BIT_NS);
    check("halt_rx_received", rx_push_cnt, base_rx + 1);
    check("halt_no_tx_edge",  tx_fall_cnt, base_fall);
    check("halt_no_done",     done_q.size(), base_done);
    check("halt_sticky",      {31'd0, dut.cpu.halt}, 32'd1);

    // Fresh run with random bytes.
    reset_n = 1'b0;
    #200;
    done_q.delete();
    done_t.delete();
    mon_q.delete();
    fall_t.delete();
    exp_q.delete();
    m_echoed = 0;
    check("rst2_halt",     {31'd0, dut.cpu.halt},      32'd0);
    check("rst2_tx_empty", {31'd0, dut.uart.tx_empty}, 32'd1);
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(negedge clk);

    b0 = 8'($urandom);
    b1 = 8'($urandom);
    send_byte(b0, 1'b1, 0.25 * BIT_NS * real'($urandom_range(0, 4)));
    model_frame(b0, 1'b1);
    send_byte(b1, 1'b1, 0.25 * BIT_NS * real'($urandom_range(0, 4)));
    model_frame(b1, 1'b1);
    wait_done("p2_done_count", 2, 30000);
    compare_echo("p2", 2);

    // LF frame now in flight; bit 2 of 0x0A is 0. Reset must force tx high at once.
    #(3.5 * BIT_NS);
    check("lf_midframe_tx",       {31'd0, tx},                32'd0);
    check("lf_midframe_tx_empty", {31'd0, dut.uart.tx_empty}, 32'd0);
    mon_en = 1'b0;
    #7;
    reset_n = 1'b0;
    #1;
    check("rst_midframe_tx",       {31'd0, tx},                    32'd1);
    check("rst_midframe_tx_empty", {31'd0, dut.uart.tx_empty},     32'd1);
    check("rst_midframe_done",     {31'd0, dut.uart.tx_done_tick}, 32'd0);
    #200;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
